// File: rtl/mul_mdc_job_sched_pkg.sv
// Shared types and constants for the mul_mdc job sequencer.
`timescale 1ns/1ps
package mul_mdc_job_sched_package;

  // state    | meaning
  // ST_IDLE  | no job, waiting for start
  // ST_ISSUE | raising transfer requests until every channel has acked
  // ST_KICK  | one-cycle engine start
  // ST_WAIT  | collecting channel and engine completion flags
  // ST_NEXT  | advance addresses and tile index
  // ST_FINISH| one-cycle job-complete event
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_KICK,
    ST_WAIT,
    ST_NEXT,
    ST_FINISH
  } state_t;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;
  localparam int CH_D = 3;
  localparam int N_CH = 4;

  // Done mask layout: [N_CH-1:0] channel completions, [DONE_ENG] engine.
  localparam int DONE_W   = N_CH + 1;
  localparam int DONE_ENG = N_CH;

endpackage

// File: rtl/mul_mdc_job_addr_gen.sv
// Per-channel address register: loads the base at job start and steps by
// the stride once per tile. Addition wraps modulo 2^AW.
`timescale 1ns/1ps
module mul_mdc_job_addr_gen #(
  parameter int AW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [AW-1:0] base_i,
  input  logic          add_i,
  input  logic [AW-1:0] stride_i,
  output logic [AW-1:0] addr_o
);

  // Address register; load wins over add.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_o <= '0;
    end else if (load_i) begin
      addr_o <= base_i;
    end else if (add_i) begin
      addr_o <= addr_o + stride_i;
    end
  end

endmodule

// File: rtl/mul_mdc_job_sched.sv
// Job-level sequencer for the mul_mdc accelerator: walks N tiles, issuing
// transfer requests on channels a/b/c/d, kicking the engine, and gathering
// completions before advancing.
// Optional build macro: MUL_MDC_JOB_SCHED_PERF_CNT_EN adds cycles_o, a
// saturating count of busy cycles for the current/last job.
//
// state     | meaning
// ST_IDLE   | no job; start_i latches config
// ST_ISSUE  | req held per channel until its ack
// ST_KICK   | eng_start_o pulse
// ST_WAIT   | wait for all 5 done flags (sticky since ISSUE)
// ST_NEXT   | clear masks, step addresses, next tile or finish
// ST_FINISH | done_evt_o pulse, back to idle
`timescale 1ns/1ps
module mul_mdc_job_sched
  import mul_mdc_job_sched_package::*;
#(
  parameter int AW = 32,
  parameter int LW = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [LW-1:0]     n_tiles_i,
  input  logic [LW-1:0]     tile_len_i,
  input  logic [AW-1:0]     stride_i,
  input  logic [4*AW-1:0]   base_addr_i,
  output logic [N_CH-1:0]   xfer_req_o,
  output logic [4*AW-1:0]   xfer_addr_o,
  output logic [LW-1:0]     xfer_len_o,
  input  logic [N_CH-1:0]   xfer_ack_i,
  input  logic [N_CH-1:0]   xfer_done_i,
  output logic              eng_start_o,
  input  logic              eng_done_i,
  output logic              busy_o,
  output logic [LW-1:0]     tile_idx_o,
  output logic              done_evt_o
`ifdef MUL_MDC_JOB_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]       cycles_o
`endif
);

  state_t              state_q, state_d;
  logic                sclr;
  logic                start_acc;
  logic [N_CH-1:0]     ack_q;
  logic [DONE_W-1:0]   done_q;
  logic [N_CH-1:0]     ack_hit;
  logic [DONE_W-1:0]   done_in;
  logic                ack_all;
  logic                done_all;
  logic                last_tile;
  logic [LW-1:0]       n_tiles_q;
  logic [LW-1:0]       len_q;
  logic [AW-1:0]       stride_q;
  logic [LW-1:0]       tile_idx_q;
  logic                addr_load;
  logic                addr_add;

  // Soft clear behaves exactly like reset and beats a same-cycle start.
  assign sclr      = rst_i | clear_i;
  assign start_acc = (state_q == ST_IDLE) && start_i;

  assign ack_hit  = xfer_req_o & xfer_ack_i;
  assign ack_all  = &(ack_q | ack_hit);
  assign done_in  = {eng_done_i, xfer_done_i};
  assign done_all = &(done_q | done_in);
  // Compare one bit wider so n_tiles = 2^LW-1 never overflows the index.
  assign last_tile = (({1'b0, tile_idx_q} + (LW+1)'(1)) == {1'b0, n_tiles_q});

  assign xfer_len_o = len_q;
  assign tile_idx_o = tile_idx_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (sclr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    state_d     = state_q;
    xfer_req_o  = '0;
    eng_start_o = 1'b0;
    busy_o      = 1'b1;
    done_evt_o  = 1'b0;
    addr_load   = 1'b0;
    addr_add    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          addr_load = 1'b1;
          state_d   = (n_tiles_i == '0) ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        xfer_req_o = ~ack_q;
        if (ack_all) state_d = ST_KICK;
      end
      ST_KICK: begin
        eng_start_o = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_all) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        addr_add = 1'b1;
        state_d  = last_tile ? ST_FINISH : ST_ISSUE;
      end
      ST_FINISH: begin
        done_evt_o = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Job config latches, handshake masks and tile index.
  always_ff @(posedge clk_i) begin
    if (sclr) begin
      n_tiles_q  <= '0;
      len_q      <= '0;
      stride_q   <= '0;
      tile_idx_q <= '0;
      ack_q      <= '0;
      done_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_acc) begin
            n_tiles_q  <= n_tiles_i;
            len_q      <= tile_len_i;
            stride_q   <= stride_i;
            tile_idx_q <= '0;
            ack_q      <= '0;
            done_q     <= '0;
          end
        end
        ST_ISSUE: begin
          ack_q  <= ack_q | ack_hit;
          done_q <= done_q | done_in;
        end
        ST_KICK, ST_WAIT: begin
          done_q <= done_q | done_in;
        end
        ST_NEXT: begin
          ack_q  <= '0;
          done_q <= '0;
          if (!last_tile) tile_idx_q <= tile_idx_q + LW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // One address generator per channel.
  for (genvar k = 0; k < N_CH; k++) begin : g_addr
    logic [AW-1:0] addr_k;
    mul_mdc_job_addr_gen #(.AW(AW)) u_addr (
      .clk_i    (clk_i),
      .rst_i    (sclr),
      .load_i   (addr_load),
      .base_i   (base_addr_i[k*AW +: AW]),
      .add_i    (addr_add),
      .stride_i (stride_q),
      .addr_o   (addr_k)
    );
    assign xfer_addr_o[k*AW +: AW] = addr_k;
  end

`ifdef MUL_MDC_JOB_SCHED_PERF_CNT_EN
  // Busy-cycle counter: zeroed at accepted start, saturating, held when idle.
  always_ff @(posedge clk_i) begin
    if (sclr) begin
      cycles_o <= '0;
    end else if (start_acc) begin
      cycles_o <= '0;
    end else if (busy_o && (cycles_o != '1)) begin
      cycles_o <= cycles_o + 32'd1;
    end
  end
`endif

endmodule
